// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port unified memory: cpu and debug/loader requesters
// are serialised through IDLE -> ACCESS -> RESP, with a counter bounding debug starvation.
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state_r;
    state_t        state_next_s;
    logic [3:0]    starve_r;
    logic [3:0]    starve_next_s;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic          owner_r;
    logic          grant_s;
    logic          grant_dbg_s;
    logic          cpu_ack_r;
    logic          dbg_ack_r;
    logic [DW-1:0] cpu_rdata_r;
    logic [DW-1:0] dbg_rdata_r;

    // Next-state, winner selection and starvation counter update
    always_comb begin
        state_next_s  = state_r;
        starve_next_s = starve_r;
        grant_s       = 1'b0;
        grant_dbg_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    grant_s      = 1'b1;
                    grant_dbg_s  = dbg_req && (!cpu_req || (starve_r == LIMIT));
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
                // A dbg grant or an absent dbg request both reset the starvation history
                if (!dbg_req || grant_dbg_s) begin
                    starve_next_s = 4'd0;
                end else if (grant_s && (starve_r != LIMIT)) begin
                    starve_next_s = starve_r + 4'd1;
                end else begin
                    starve_next_s = starve_r;
                end
            end
            ACCESS:  state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, latched request, acks and per-port read data registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            starve_r    <= 4'd0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            owner_r     <= 1'b0;
            cpu_ack_r   <= 1'b0;
            dbg_ack_r   <= 1'b0;
            cpu_rdata_r <= '0;
            dbg_rdata_r <= '0;
        end else begin
            state_r  <= state_next_s;
            starve_r <= starve_next_s;
            if (grant_s) begin
                owner_r <= grant_dbg_s;
                we_r    <= grant_dbg_s ? dbg_we : cpu_we;
                addr_r  <= grant_dbg_s ? {dbg_addr[AW-1:2], 2'b00} : {cpu_addr[AW-1:2], 2'b00};
                wdata_r <= grant_dbg_s ? dbg_wdata : cpu_wdata;
            end
            cpu_ack_r <= (state_r == ACCESS) && !owner_r;
            dbg_ack_r <= (state_r == ACCESS) && owner_r;
            if ((state_r == ACCESS) && !we_r) begin
                if (owner_r) begin
                    dbg_rdata_r <= mem_rd;
                end else begin
                    cpu_rdata_r <= mem_rd;
                end
            end
        end
    end

    // Write enable is gated by reset combinationally so an aborted access never writes
    assign mem_we    = (state_r == ACCESS) && we_r && reset_n;
    assign mem_a     = addr_r;
    assign mem_wd    = wdata_r;
    assign cpu_ack   = cpu_ack_r;
    assign dbg_ack   = dbg_ack_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dbg_rdata = dbg_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = 32'd0, dbg_wdata = 32'd0;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:63];
    logic        loaded = 1'b0;
    int          checks = 0;
    int          errors = 0;

    mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    // Memory model: preload once, then write on rising edge when enabled
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[0]  <= 32'h2002_0005;
            mem[16] <= 32'hCAFE_F00D;
            loaded  <= 1'b1;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Holds nothing itself; records ack owners (bit i = 1 when transaction i went to dbg)
    task automatic collect_grants(input int n, output logic [7:0] who, output int got, output int both);
        who = 8'd0; got = 0; both = 0;
        for (int c = 0; c < n * 3 + 6 && got < n; c++) begin
            cyc();
            if (cpu_ack && dbg_ack) both++;
            if (cpu_ack || dbg_ack) begin
                who[got] = dbg_ack;
                got++;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) cyc();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b expected 0", cpu_ack); end
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_dbg_ack: got %b expected 0", dbg_ack); end
        checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_dbg_rdata: got %h expected 0", dbg_rdata); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_a !== 32'd0 || mem_wd !== 32'd0) begin errors++; $display("FAIL reset_mem_bus: got a=%h wd=%h expected 0/0", mem_a, mem_wd); end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_cpu_read;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        cyc();
        checks++; if (mem_we !== 1'b0 || mem_a !== 32'h0) begin errors++; $display("FAIL rd_access: got we=%b a=%h expected 0/0", mem_we, mem_a); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack: got %b expected 0", cpu_ack); end
        cyc();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b expected 1", cpu_ack); end
        checks++; if (cpu_rdata !== 32'h2002_0005) begin errors++; $display("FAIL rd_data: got %h expected 20020005", cpu_rdata); end
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL rd_dbg_ack: got %b expected 0", dbg_ack); end
        cpu_req = 1'b0;
        cyc();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse: got %b expected 0", cpu_ack); end
    endtask

    task automatic test_dbg_write_cpu_read;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'hDEAD_BEEF;
        cyc();
        checks++; if (mem_we !== 1'b1 || mem_a !== 32'h44 || mem_wd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_access: got we=%b a=%h wd=%h expected 1/44/deadbeef", mem_we, mem_a, mem_wd); end
        cyc();
        checks++; if (dbg_ack !== 1'b1 || cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack: got dbg=%b cpu=%b expected 1/0", dbg_ack, cpu_ack); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_once: got %b expected 0", mem_we); end
        checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL wr_rdata_kept: got %h expected 0", dbg_rdata); end
        dbg_req = 1'b0; dbg_we = 1'b0;
        cyc();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h46;
        cyc();
        checks++; if (mem_a !== 32'h44 || mem_we !== 1'b0) begin errors++; $display("FAIL rd46_access: got a=%h we=%b expected 44/0", mem_a, mem_we); end
        cyc();
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd46_data: got ack=%b data=%h expected 1/deadbeef", cpu_ack, cpu_rdata); end
        cpu_req = 1'b0;
        cyc();
    endtask

    task automatic test_starvation;
        logic [7:0] who; int got; int both;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'hC;
        collect_grants(6, who, got, both);
        cpu_req = 1'b0; dbg_req = 1'b0;
        checks++; if (got !== 6) begin errors++; $display("FAIL starve_count: got %0d expected 6", got); end
        checks++; if (who[5:0] !== 6'b010000) begin errors++; $display("FAIL starve_order: got %b expected 010000", who[5:0]); end
        checks++; if (both !== 0) begin errors++; $display("FAIL starve_dual_ack: got %0d expected 0", both); end
        checks++; if (dbg_rdata !== 32'h1000_0003) begin errors++; $display("FAIL starve_dbg_data: got %h expected 10000003", dbg_rdata); end
        cyc();
    endtask

    task automatic test_starve_clear;
        logic [7:0] who; int got; int both;
        cpu_req = 1'b1; dbg_req = 1'b1;
        collect_grants(2, who, got, both);
        cpu_req = 1'b0; dbg_req = 1'b0;
        checks++; if (got !== 2 || who[1:0] !== 2'b00) begin errors++; $display("FAIL clear_pre: got n=%0d who=%b expected 2/00", got, who[1:0]); end
        cyc(); cyc();
        cpu_req = 1'b1; dbg_req = 1'b1;
        collect_grants(5, who, got, both);
        cpu_req = 1'b0; dbg_req = 1'b0;
        checks++; if (got !== 5 || who[4:0] !== 5'b10000) begin errors++; $display("FAIL clear_order: got n=%0d who=%b expected 5/10000", got, who[4:0]); end
        cyc();
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic [31:0] exp_data [3];
        logic        exp_ack;
        int          t;
        addrs = '{32'h8, 32'hC, 32'h10};
        exp_data = '{32'h1000_0002, 32'h1000_0003, 32'h1000_0004};
        t = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addrs[0];
        for (int k = 1; k <= 9; k++) begin
            cyc();
            exp_ack = ((k % 3) == 2);
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b_we c%0d: got %b expected 0", k, mem_we); end
            checks++; if (cpu_ack !== exp_ack) begin errors++; $display("FAIL b2b_ack c%0d: got %b expected %b", k, cpu_ack, exp_ack); end
            if (exp_ack && t < 3) begin
                checks++; if (cpu_rdata !== exp_data[t]) begin errors++; $display("FAIL b2b_data %0d: got %h expected %h", t, cpu_rdata, exp_data[t]); end
                t++;
                if (t < 3) cpu_addr = addrs[t];
                else cpu_req = 1'b0;
            end
        end
        cyc();
    endtask

    task automatic test_reset_mid_access;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678;
        cyc();
        reset_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", mem_we); end
        cyc();
        checks++; if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b/%b expected 0/0", cpu_ack, dbg_ack); end
        checks++; if (cpu_rdata !== 32'd0 || mem_a !== 32'd0 || mem_wd !== 32'd0) begin
            errors++; $display("FAIL rst_outs: got rdata=%h a=%h wd=%h expected 0", cpu_rdata, mem_a, mem_wd); end
        reset_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++; if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_after c%0d: got ack=%b we=%b expected 0/0", k, cpu_ack, mem_we); end
        end
        checks++; if (mem[16] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_mem: got %h expected cafef00d", mem[16]); end
        // A fresh read afterwards confirms the FSM restarted from IDLE
        cpu_req = 1'b1; cpu_addr = 32'h40;
        cyc(); cyc();
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL rst_recover: got ack=%b data=%h expected 1/cafef00d", cpu_ack, cpu_rdata); end
        cpu_req = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dbg_write_cpu_read();
        test_starvation();
        test_starve_clear();
        test_back_to_back();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port unified instruction/data memory of the multi-cycle processor between two requesters.
- Requester 1 is the processor's memory interface (cpu); requester 2 is the debug/program-loader port (dbg).
- Serialises accesses through a 3-state FSM, registers request and response, and bounds dbg starvation with a consecutive-grant counter.
- Sits between the processor/loader and the memory (combinational read, write on rising clk edge when we=1).

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, max consecutive cpu grants while dbg_req is pending; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- cpu_req  in  1  cpu request level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  DW  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data, valid while cpu_ack=1.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as cpu_* for the debug port.
- mem_we  out  1  memory write enable.
- mem_a  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data (combinational).

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; starve counter=0; latched we/addr/wdata=0; owner=cpu.
  - Outputs: cpu_ack=dbg_ack=0, cpu_rdata=dbg_rdata=0, mem_a=0, mem_wd=0.
  - mem_we=0 combinationally whenever reset_n=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: choose a winner, latch its we/addr/wdata and owner, go to ACCESS.
  - Winner selection: cpu wins a simultaneous request unless the starve counter equals STARVE_LIMIT; then dbg wins.
- ACCESS (exactly one cycle):
  - mem_a = latched addr with bits [1:0] forced to 0; mem_wd = latched wdata.
  - mem_we = latched we & reset_n.
  - For reads, mem_rd is captured into the owner's rdata register at the end of the cycle.
  - For writes, the owner's rdata register is left unchanged.
  - Next state: RESP.
- RESP (exactly one cycle): owner's ack=1, the other port's ack=0. Next state: IDLE.
- Outside ACCESS: mem_we=0; mem_a and mem_wd hold their last values.
- Latency: request sampled in IDLE at edge N; mem access in cycle N+1; ack visible in cycle N+2. A new grant is possible at edge N+3, giving 3 cycles per transaction.
- Handshake:
  - Requester holds req and its signals stable until its ack.
  - Requester drops req at the edge after ack unless it issues a new transaction.
  - req still high in IDLE is treated as a new request.
  - Signal changes after the latching edge have no effect.
  - The losing requester waits with no ack; it is never dropped.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each cpu grant while dbg_req=1.
  - Clears on a dbg grant or whenever dbg_req=0 in IDLE.
- Reset mid-operation:
  - Reset asserted during ACCESS suppresses the write and aborts the transaction; no ack is ever issued for it.
  - Reset during RESP kills the ack in the following cycle.
- Back-to-back transactions from the same port are allowed; arbitration re-runs every IDLE cycle.
- rdata registers hold their value after ack until the next read completes for that port.

Test Plan:
- Single cpu read, mem word 0 = 0x20020005, cpu_addr=0x0 -> mem_we=0 in ACCESS; cpu_ack pulses 2 cycles after the request edge with cpu_rdata=0x20020005; dbg_ack stays 0.
- dbg write then cpu read: dbg writes 0xDEADBEEF to addr 0x44 -> mem_we=1 for exactly one cycle with mem_a=0x44; a following cpu read of 0x46 returns 0xDEADBEEF (mem_a=0x44).
- Simultaneous cpu and dbg requests, both held continuously -> grants in order cpu,cpu,cpu,cpu,dbg,cpu…; dbg is served on the 5th transaction with STARVE_LIMIT=4.
- dbg_req dropped after 2 cpu grants, then reasserted -> counter cleared; dbg waits a full 4 cpu grants before being served.
- reset_n=0 during the ACCESS cycle of a cpu write of 0x12345678 to 0x40 -> mem_we never high, memory word at 0x40 unchanged, no cpu_ack, FSM in IDLE with all outputs 0.
- cpu issues 3 back-to-back reads with dbg idle -> acks at cycles N+2, N+5, N+8 with correct data; mem_we=0 throughout.
